// File: rtl/arb_client_pkg.sv
// Shared defaults and FSM state type for the arbiter request client.
package arb_client_pkg;

  localparam int unsigned ARB_NPORT     = 4;
  localparam int unsigned ARB_CNT_W     = 4;
  localparam int unsigned ARB_BURST_LEN = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/arb_pend_cnt.sv
// Saturating up/down pending-job counter for one requester port.
module arb_pend_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nonzero
);

  logic [CNT_W-1:0] cnt;
  logic             inc_ok;
  logic             dec_ok;

  assign full    = &cnt;
  assign nonzero = |cnt;
  assign inc_ok  = inc & ~full;
  assign dec_ok  = dec & nonzero;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/arb_req_client.sv
// Per-port job queueing toward a round-robin arbiter, owning a shared
// resource for BURST_LEN cycles per grant, with grant protocol checking.
module arb_req_client
  import arb_client_pkg::*;
#(
  parameter int unsigned NPORT     = ARB_NPORT,
  parameter int unsigned CNT_W     = ARB_CNT_W,
  parameter int unsigned BURST_LEN = ARB_BURST_LEN
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NPORT-1:0]         job_valid,
  output logic [NPORT-1:0]         job_ready,
  output logic [NPORT-1:0]         request,
  input  logic [NPORT-1:0]         grant,
  output logic                     busy,
  output logic [$clog2(NPORT)-1:0] busy_port,
  output logic [NPORT-1:0]         done,
  output logic                     proto_err,
  input  logic                     err_clr
);

  localparam int unsigned PW = $clog2(NPORT);

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      burst_cnt;
  logic [7:0]      burst_cnt_nxt;
  logic [PW-1:0]   owner_nxt;
  logic [PW-1:0]   grant_idx;
  logic [NPORT-1:0] full;
  logic [NPORT-1:0] nonzero;
  logic [NPORT-1:0] dec;
  logic            grant_any;
  logic            grant_stray;
  logic            violation;
  logic            accept;

  for (genvar g = 0; g < NPORT; g++) begin : g_cnt
    arb_pend_cnt #(.CNT_W(CNT_W)) u_pend_cnt (
      .clk     (clk),
      .rst_b   (rst_b),
      .inc     (job_valid[g]),
      .dec     (dec[g]),
      .full    (full[g]),
      .nonzero (nonzero[g])
    );
  end

  assign job_ready = ~full;
  assign busy      = (state == BUSY);

  // request depends only on registered state, never on grant
  always_comb begin
    request = '0;
    if (state == IDLE) request = nonzero;
  end

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  assign grant_any   = |grant;
  assign grant_stray = |(grant & ~request);
  assign violation   = grant_any && (!$onehot(grant) || grant_stray || (state == BUSY));
  assign accept      = (state == IDLE) && grant_any && !violation;
  assign dec         = accept ? grant : '0;

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    owner_nxt     = busy_port;
    done          = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt     = BUSY;
          burst_cnt_nxt = '0;
          owner_nxt     = grant_idx;
        end
      end
      BUSY: begin
        if (burst_cnt == 8'(BURST_LEN - 1)) begin
          state_nxt       = IDLE;
          burst_cnt_nxt   = '0;
          owner_nxt       = '0;
          done[busy_port] = 1'b1;
        end else begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      burst_cnt <= '0;
      busy_port <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      busy_port <= owner_nxt;
    end
  end

  // a violation in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      proto_err <= 1'b0;
    end else if (violation) begin
      proto_err <= 1'b1;
    end else if (err_clr) begin
      proto_err <= 1'b0;
    end
  end

endmodule
